// File: rtl/cmul_accum_if.sv
// Stream bundle between the complex product source, the accumulator and its
// result consumer: product stream in, block-sum stream out.
interface cmul_accum_if #(
  parameter int ACC_W = 12
) ();
  logic             in_valid;
  logic             in_ready;
  logic [8:0]       p_r;
  logic [8:0]       p_i;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum_r;
  logic [ACC_W-1:0] sum_i;

  modport master (
    output in_valid, p_r, p_i, out_ready,
    input  in_ready, out_valid, sum_r, sum_i
  );

  modport slave (
    input  in_valid, p_r, p_i, out_ready,
    output in_ready, out_valid, sum_r, sum_i
  );
endinterface

// File: rtl/cmul_accum.sv
// Complex block accumulator: sums LEN consecutive 9-bit complex products and
// presents each block sum on a valid/ready port while the next block builds.
module cmul_accum #(
  parameter int LEN   = 8,
  parameter int ACC_W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  cmul_accum_if.slave  bus
);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  function automatic logic [ACC_W-1:0] sext9(input logic [8:0] p);
    return {{(ACC_W-9){p[8]}}, p};
  endfunction

  logic [ACC_W-1:0] acc_re_r;
  logic [ACC_W-1:0] acc_im_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] sum_re_r;
  logic [ACC_W-1:0] sum_im_r;
  logic             out_valid_r;

  logic             last_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [ACC_W-1:0] next_re_s;
  logic [ACC_W-1:0] next_im_s;

  // Handshake decode and running sums including the presented product
  always_comb begin
    last_s     = (cnt_r == CNT_W'(LEN - 1));
    // Only the closing product of a block can collide with an unaccepted result
    in_ready_s = !clr && !(last_s && out_valid_r && !bus.out_ready);
    accept_s   = bus.in_valid && in_ready_s;
    next_re_s  = acc_re_r + sext9(bus.p_r);
    next_im_s  = acc_im_r + sext9(bus.p_i);
  end

  // Accumulator and product counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_r <= {ACC_W{1'b0}};
      acc_im_r <= {ACC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (clr) begin
      acc_re_r <= {ACC_W{1'b0}};
      acc_im_r <= {ACC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (accept_s && last_s) begin
      acc_re_r <= {ACC_W{1'b0}};
      acc_im_r <= {ACC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      acc_re_r <= next_re_s;
      acc_im_r <= next_im_s;
      cnt_r    <= cnt_r + CNT_W'(1);
    end else begin
      acc_re_r <= acc_re_r;
      acc_im_r <= acc_im_r;
      cnt_r    <= cnt_r;
    end
  end

  // Result register: loads on block completion, holds until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_re_r    <= {ACC_W{1'b0}};
      sum_im_r    <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (accept_s && last_s) begin
      sum_re_r    <= next_re_s;
      sum_im_r    <= next_im_s;
      out_valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      sum_re_r    <= sum_re_r;
      sum_im_r    <= sum_im_r;
      out_valid_r <= 1'b0;
    end else begin
      sum_re_r    <= sum_re_r;
      sum_im_r    <= sum_im_r;
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum_r     = sum_re_r;
  assign bus.sum_i     = sum_im_r;
endmodule

// File: tb/tb_cmul_accum.sv
// Bench for cmul_accum: directed scenarios plus a randomized run, checked by a
// product-group reference model feeding a scoreboard drained by a monitor.
module tb_cmul_accum;
  localparam int LEN   = 8;
  localparam int ACC_W = 12;

  typedef struct packed {
    logic [ACC_W-1:0] re;
    logic [ACC_W-1:0] im;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  cmul_accum_if #(.ACC_W(ACC_W)) bus ();

  cmul_accum #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  int   blk_r[$];
  int   blk_i[$];
  bit   pending_m = 1'b0;
  int   blocks_pushed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: collects accepted products into groups of LEN
  always @(negedge clk) begin : model
    bit   exp_ready;
    int   sr;
    int   si;
    res_t e;
    if (!rst_n) begin
      blk_r.delete();
      blk_i.delete();
      exp_q.delete();
      pending_m = 1'b0;
    end else begin
      exp_ready = !clr && !((blk_r.size() == LEN - 1) && pending_m && !bus.out_ready);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(pending_m));
      if (clr) begin
        blk_r.delete();
        blk_i.delete();
        if (bus.out_ready) pending_m = 1'b0;
      end else if (bus.in_valid && exp_ready) begin
        blk_r.push_back(int'($signed(bus.p_r)));
        blk_i.push_back(int'($signed(bus.p_i)));
        if (blk_r.size() == LEN) begin
          sr = 0;
          si = 0;
          foreach (blk_r[k]) begin
            sr += blk_r[k];
            si += blk_i[k];
          end
          e.re = sr[ACC_W-1:0];
          e.im = si[ACC_W-1:0];
          exp_q.push_back(e);
          blocks_pushed++;
          blk_r.delete();
          blk_i.delete();
          pending_m = 1'b1;
        end else if (bus.out_ready) begin
          pending_m = 1'b0;
        end
      end else if (bus.out_ready) begin
        pending_m = 1'b0;
      end
    end
  end

  // Monitor: every accepted result must match the oldest expected sum
  always @(negedge clk) begin : monitor
    res_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h/%0h expected none", bus.sum_r, bus.sum_i);
      end else begin
        e = exp_q.pop_front();
        chk("sum_r", 32'(bus.sum_r), 32'(e.re));
        chk("sum_i", 32'(bus.sum_i), 32'(e.im));
      end
    end
  end

  task automatic send(input int pr, input int pi);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.p_r      = pr[8:0];
    bus.p_i      = pi[8:0];
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b expected 1 within 200 cycles", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_n(input int pr, input int pi, input int n);
    for (int k = 0; k < n; k++) send(pr, pi);
  endtask

  initial begin
    int  base;
    int  cyc;
    bit  held;
    bus.in_valid  = 1'b0;
    bus.p_r       = 9'd0;
    bus.p_i       = 9'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum_r", 32'(bus.sum_r), 32'd0);
    chk("rst_sum_i", 32'(bus.sum_i), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic sum
    send_n(1, -1, LEN);
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_sum_r", 32'(bus.sum_r), 32'h008);
    chk("basic_sum_i", 32'(bus.sum_i), 32'hFF8);
    @(posedge clk);
    #1;
    chk("basic_drop", 32'(bus.out_valid), 32'd0);

    // Extremes, then back-to-back block
    send_n(-256, 255, LEN);
    chk("ext_sum_r", 32'(bus.sum_r), 32'h800);
    chk("ext_sum_i", 32'(bus.sum_i), 32'h7F8);
    send_n(3, -5, LEN);
    chk("b2b_sum_r", 32'(bus.sum_r), 32'h018);
    chk("b2b_sum_i", 32'(bus.sum_i), 32'hFD8);
    @(posedge clk);
    #1;

    // Backpressure
    bus.out_ready = 1'b0;
    send_n(1, -1, LEN);
    send_n(2, -2, LEN - 1);
    bus.in_valid = 1'b1;
    bus.p_r      = 9'd2;
    bus.p_i      = 9'h1FE;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_r", 32'(bus.sum_r), 32'h008);
      chk("bp_hold_i", 32'(bus.sum_i), 32'hFF8);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_sum_r", 32'(bus.sum_r), 32'h010);
    chk("bp_sum_i", 32'(bus.sum_i), 32'hFF0);
    @(posedge clk);
    #1;

    // clr mid-block with a pending result
    bus.out_ready = 1'b0;
    send_n(5, 0, LEN);
    send_n(10, 0, 3);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.p_r      = 9'd10;
    bus.p_i      = 9'd0;
    #1;
    chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_keep_valid", 32'(bus.out_valid), 32'd1);
    chk("clr_keep_sum", 32'(bus.sum_r), 32'h028);
    bus.out_ready = 1'b1;
    send_n(1, 0, LEN);
    chk("clr_sum_r", 32'(bus.sum_r), 32'h008);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-block with a pending result
    bus.out_ready = 1'b0;
    send_n(1, 1, LEN);
    send_n(2, 2, 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_sum_r", 32'(bus.sum_r), 32'd0);
    chk("arst_sum_i", 32'(bus.sum_i), 32'd0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    send_n(-1, 0, LEN);
    chk("arst_sum", 32'(bus.sum_r), 32'hFF8);
    @(posedge clk);
    #1;

    // Randomized traffic with random source gaps and sink stalls
    base = blocks_pushed;
    cyc  = 0;
    while (blocks_pushed < base + 1000 && cyc < 60000) begin
      @(negedge clk);
      held = bus.in_valid && !bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (!held) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.p_r      = 9'($urandom_range(0, 511));
        bus.p_i      = 9'($urandom_range(0, 511));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    if (blocks_pushed < base + 1000) begin
      checks++;
      errors++;
      $display("FAIL random_timeout: blocks=%0d expected %0d", blocks_pushed - base, 1000);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmul_accum.md
# cmul_accum

Complex accumulator sitting directly downstream of the registered 4-bit complex multiplier. It consumes the multiplier's 9-bit signed real/imaginary products, sums LEN consecutive products into a complex dot-product result, and presents each result with a valid/ready handshake. Accumulation of the next block overlaps with a pending, un-accepted result. Input is stalled only when a second result would overwrite one that has not been accepted.

## Interface
- LEN, 8: products per block; power of two, 2..256.
- ACC_W, 12: accumulator/output width; must be ≥ 9 + log2(LEN).
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush of the in-progress block.
- in_valid  in  1  product valid.
- in_ready  out  1  block can accept a product this cycle; combinational.
- p_r  in  9  real product, two's complement.
- p_i  in  9  imaginary product, two's complement.
- out_valid  out  1  sum_r/sum_i hold a completed block; registered.
- out_ready  in  1  downstream accepts the result.
- sum_r  out  ACC_W  real block sum, two's complement; registered.
- sum_i  out  ACC_W  imaginary block sum, two's complement; registered.

## Operation
- Accept: an edge with in_valid && in_ready.
- Internal state:
  - acc_r, acc_i (ACC_W each);
  - cnt (log2(LEN) bits, 0..LEN-1);
  - output registers sum_r/sum_i/out_valid.
- Arithmetic:
  - p_r/p_i are sign-extended to ACC_W and added to acc_r/acc_i.
  - Addition is modulo 2^ACC_W (wraps, no saturation).
  - With ACC_W ≥ 9+log2(LEN), overflow cannot occur.
- Non-final accept (cnt < LEN-1): acc += p, cnt++.
- Final accept (cnt == LEN-1):
  - sum_r/sum_i load acc_r + p_r and acc_i + p_i;
  - out_valid is set;
  - acc is cleared to 0 and cnt to 0 in the same edge.
- Output hold: out_valid stays high and sum_r/sum_i stay stable until an edge with out_ready high.
  - That edge clears out_valid, unless a final accept occurs on the same edge.
  - In that case out_valid stays 1 and sum loads the new result.
- in_ready = !clr && !(cnt == LEN-1 && out_valid && !out_ready).
  - Non-final products are always accepted (when clr is low), even while a result is pending.
- clr:
  - Sets acc=0 and cnt=0.
  - Does not alter sum_r/sum_i/out_valid.
  - Forces in_ready low, so a product presented with clr is not accepted.
- in_valid high while in_ready is low: the product is not consumed and the source must hold it.
- Out-of-range p values are not possible: all 9-bit codes, -256..255, are legal.

## Timing
- Reset (rst_n low, asynchronous, any time, including mid-block or with out_valid high):
  - acc_r=acc_i=0, cnt=0, sum_r=sum_i=0, out_valid=0.
  - in_ready is 1 after release (given clr low).
  - The partial block and any pending result are discarded.
- Latency: out_valid rises on the edge that accepts the LEN-th product, and is visible in the following cycle.
- Throughput: one product per cycle sustained when out_ready is high.
  - With out_ready tied high, a result appears every LEN cycles.
  - Back-to-back blocks need no idle cycle.
- Backpressure:
  - With out_ready low, the next block accumulates through LEN-1 products.
  - in_ready then drops at cnt == LEN-1 and rises combinationally in the cycle out_ready goes high.
- Simultaneous clr and final product: clr wins; no result is produced and the product is not consumed.
- A pending result is never overwritten before its accepting edge.

## Test plan
- Basic sum: LEN=8, 8 consecutive products p_r=1, p_i=-1, out_ready=1 → one cycle after the 8th accept, out_valid=1, sum_r=8, sum_i=-8 (0xFF8); out_valid drops on the next edge.
- Extremes: 8× (p_r=-256, p_i=255) → sum_r=-2048 (0x800), sum_i=2040 (0x7F8); then 8× (p_r=3, p_i=-5) back-to-back → sum_r=24, sum_i=-40 with no idle cycle; acc verifiably restarts at 0.
- Backpressure: out_ready=0 after block 1 (result 8/-8); stream block 2 with p=2 → 7 products accepted; in_ready=0 with the 8th held, sum still 8/-8; raise out_ready → 8th accepted that edge, out_valid stays 1, sum becomes 16/-16.
- clr mid-block: accept 3 products of p_r=10, assert clr with in_valid, p_r=10 → not accepted; then 8× p_r=1 → sum_r=8. A pending out_valid held across clr is unchanged.
- Reset mid-operation: pulse rst_n low asynchronously (between edges) at cnt=5 with out_valid=1 → all outputs 0 immediately; after release, 8× p_r=-1 → sum_r=-8.
- Random: 1000 blocks of random 9-bit p and random in_valid/out_ready → scoreboard matches the modulo-2^ACC_W sum of each LEN-group in order; no result is lost or duplicated.
